// File: rtl/regfile_read_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_read_sequencer
//
// Read-side controller for the bit-cell register file. Accepts a two-operand
// read request and drives one-hot read enables onto both read ports. It holds
// them while the shared bitlines settle, then captures both words. Register 0
// always reads as zero. A write landing on the capture edge is forwarded.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready is registered)
//   req_addr1/req_addr2   register indices for read ports 1 and 2
//   ReadEnable1/2         one-hot per-register read enables (registered)
//   Bitline1/2            bitline buses returned by the array
//   wr_en/wr_addr/wr_data write-path snoop used for forwarding
//   rsp_valid/rsp_ready   response handshake
//   rsp_data1/rsp_data2   captured words
//   rsp_err               at least one index was >= NUM_REGS
// ---------------------------------------------------------------------------
module regfile_read_sequencer #(
    parameter int NUM_REGS      = 16,
    parameter int ADDR_W        = 4,
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr1,
    input  logic [ADDR_W-1:0]   req_addr2,
    output logic [NUM_REGS-1:0] ReadEnable1,
    output logic [NUM_REGS-1:0] ReadEnable2,
    input  logic [DATA_W-1:0]   Bitline1,
    input  logic [DATA_W-1:0]   Bitline2,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data1,
    output logic [DATA_W-1:0]   rsp_data2,
    output logic                rsp_err
);

    localparam int             CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr1_q, addr1_d;
    logic [ADDR_W-1:0]   addr2_q, addr2_d;
    logic [NUM_REGS-1:0] re1_q, re1_d;
    logic [NUM_REGS-1:0] re2_q, re2_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data1_q, rsp_data1_d;
    logic [DATA_W-1:0]   rsp_data2_q, rsp_data2_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W:0]     cap1, cap2;

    // Register 0 is hardwired and out-of-range indices select nothing,
    // so bit 0 is never driven.
    function automatic logic [NUM_REGS-1:0] decode_en(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] en;
        en = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            en[i] = (32'(addr) == i);
        end
        return en;
    endfunction

    // Returns {err, word} for one port, applying zero-register, range,
    // forwarding and bitline sources in priority order.
    function automatic logic [DATA_W:0] capture_word(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] bitline,
        input logic              fwd_en,
        input logic [ADDR_W-1:0] fwd_addr,
        input logic [DATA_W-1:0] fwd_data
    );
        if (addr == '0) begin
            return '0;
        end
        if (32'(addr) >= NUM_REGS) begin
            return {1'b1, {DATA_W{1'b0}}};
        end
        // addr is nonzero here, so a match also implies fwd_addr != 0.
        if (fwd_en && (fwd_addr == addr)) begin
            return {1'b0, fwd_data};
        end
        return {1'b0, bitline};
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        re1_d       = re1_q;
        re2_d       = re2_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data1_d = rsp_data1_q;
        rsp_data2_d = rsp_data2_q;
        rsp_err_d   = rsp_err_q;
        cap1        = capture_word(addr1_q, Bitline1, wr_en, wr_addr, wr_data);
        cap2        = capture_word(addr2_q, Bitline2, wr_en, wr_addr, wr_data);

        unique case (state_q)
            IDLE: begin
                // req_ready comes up on the first edge after reset release.
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    addr1_d     = req_addr1;
                    addr2_d     = req_addr2;
                    cnt_d       = CNT_LOAD;
                    re1_d       = decode_en(req_addr1);
                    re2_d       = decode_en(req_addr2);
                    req_ready_d = 1'b0;
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    rsp_data1_d = cap1[DATA_W-1:0];
                    rsp_data2_d = cap2[DATA_W-1:0];
                    rsp_err_d   = cap1[DATA_W] | cap2[DATA_W];
                    rsp_valid_d = 1'b1;
                    re1_d       = '0;
                    re2_d       = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr1_q     <= '0;
            addr2_q     <= '0;
            re1_q       <= '0;
            re2_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            re1_q       <= re1_d;
            re2_q       <= re2_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data1_q <= rsp_data1_d;
            rsp_data2_q <= rsp_data2_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign ReadEnable1 = re1_q;
    assign ReadEnable2 = re2_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data1   = rsp_data1_q;
    assign rsp_data2   = rsp_data2_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_regfile_read_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_read_sequencer
//
// Two sequencer instances share one set of inputs: one settles in a single
// cycle, the other in three. Each transaction is checked on the instance
// selected by 'sel' against a reference built from the read rules.
// ---------------------------------------------------------------------------
module tb_regfile_read_sequencer;

    localparam int NR = 16;
    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          rsp_ready;
    logic          wr_en;
    logic [AW-1:0] req_addr1, req_addr2, wr_addr;
    logic [DW-1:0] bl1, bl2, wr_data;

    logic          rdy_a, vld_a, err_a;
    logic [NR-1:0] re1_a, re2_a;
    logic [DW-1:0] d1_a, d2_a;
    logic          rdy_b, vld_b, err_b;
    logic [NR-1:0] re1_b, re2_b;
    logic [DW-1:0] d1_b, d2_b;

    int            sel;
    logic          o_rdy, o_vld, o_err;
    logic [NR-1:0] o_re1, o_re2;
    logic [DW-1:0] o_d1, o_d2;

    int checks = 0;
    int errors = 0;

    regfile_read_sequencer #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a),
        .req_addr1(req_addr1), .req_addr2(req_addr2),
        .ReadEnable1(re1_a), .ReadEnable2(re2_a),
        .Bitline1(bl1), .Bitline2(bl2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsp_valid(vld_a), .rsp_ready(rsp_ready),
        .rsp_data1(d1_a), .rsp_data2(d2_a), .rsp_err(err_a)
    );

    regfile_read_sequencer #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SETTLE_CYCLES(3)) u_s3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b),
        .req_addr1(req_addr1), .req_addr2(req_addr2),
        .ReadEnable1(re1_b), .ReadEnable2(re2_b),
        .Bitline1(bl1), .Bitline2(bl2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsp_valid(vld_b), .rsp_ready(rsp_ready),
        .rsp_data1(d1_b), .rsp_data2(d2_b), .rsp_err(err_b)
    );

    assign o_rdy = (sel == 3) ? rdy_b : rdy_a;
    assign o_vld = (sel == 3) ? vld_b : vld_a;
    assign o_err = (sel == 3) ? err_b : err_a;
    assign o_re1 = (sel == 3) ? re1_b : re1_a;
    assign o_re2 = (sel == 3) ? re2_b : re2_a;
    assign o_d1  = (sel == 3) ? d1_b  : d1_a;
    assign o_d2  = (sel == 3) ? d2_b  : d2_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: enable bit for an index, and the word a port must return.
    function automatic int exp_en(input int a);
        return (a > 0 && a < NR) ? (1 << a) : 0;
    endfunction

    function automatic int exp_word(input int a, input int bl, input int we, input int wa, input int wd);
        if (a == 0 || a >= NR) return 0;
        if (we != 0 && wa == a) return wd;
        return bl;
    endfunction

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(rdy_a && rdy_b && !vld_a && !vld_b) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_ready", 32'(o_rdy), 32'd1);
    endtask

    // One read on instance s. cw* is the write seen on the capture edge,
    // ew* the write driven in earlier DRIVE cycles. hold > 0 stalls the
    // response and queues a second request (indices 9/10) meanwhile.
    task automatic xact(input int s, input int a1, input int a2, input int b1, input int b2,
                        input int cwe, input int cwa, input int cwd,
                        input int ewe, input int ewa, input int ewd, input int hold);
        int e1, e2, ee;
        sel = s;
        wait_idle();
        req_addr1 = AW'(a1);
        req_addr2 = AW'(a2);
        bl1       = DW'(b1);
        bl2       = DW'(b2);
        wr_en     = 1'b0;
        req_valid = 1'b1;
        for (int k = 1; k <= s; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk("drive_en1", 32'(o_re1), exp_en(a1));
            chk("drive_en2", 32'(o_re2), exp_en(a2));
            chk("drive_vld", 32'(o_vld), 32'd0);
            chk("drive_rdy", 32'(o_rdy), 32'd0);
            if (k == s) begin
                wr_en   = cwe[0];
                wr_addr = AW'(cwa);
                wr_data = DW'(cwd);
                if (hold > 0) rsp_ready = 1'b0;
            end else begin
                wr_en   = ewe[0];
                wr_addr = AW'(ewa);
                wr_data = DW'(ewd);
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        e1 = exp_word(a1, b1, cwe, cwa, cwd);
        e2 = exp_word(a2, b2, cwe, cwa, cwd);
        ee = (a1 >= NR || a2 >= NR) ? 1 : 0;
        chk("rsp_vld", 32'(o_vld), 32'd1);
        chk("rsp_d1", 32'(o_d1), e1);
        chk("rsp_d2", 32'(o_d2), e2);
        chk("rsp_err", 32'(o_err), ee);
        chk("rsp_en1_off", 32'(o_re1), 32'd0);
        chk("rsp_en2_off", 32'(o_re2), 32'd0);
        chk("rsp_rdy", 32'(o_rdy), 32'd0);
        if (hold > 0) begin
            req_addr1 = AW'(9);
            req_addr2 = AW'(10);
            req_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("bp_vld", 32'(o_vld), 32'd1);
                chk("bp_d1", 32'(o_d1), e1);
                chk("bp_d2", 32'(o_d2), e2);
                chk("bp_rdy", 32'(o_rdy), 32'd0);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            chk("bp_idle_vld", 32'(o_vld), 32'd0);
            chk("bp_idle_rdy", 32'(o_rdy), 32'd1);
            chk("bp_idle_en1", 32'(o_re1), 32'd0);
            @(negedge clk);
            req_valid = 1'b0;
            chk("bp_second_rdy", 32'(o_rdy), 32'd0);
            chk("bp_second_en1", 32'(o_re1), exp_en(9));
            chk("bp_second_en2", 32'(o_re2), exp_en(10));
        end else begin
            @(negedge clk);
            chk("done_vld", 32'(o_vld), 32'd0);
            chk("done_rdy", 32'(o_rdy), 32'd1);
        end
    endtask

    initial begin
        int s, a1, a2, cwe, cwa, ewe, ewa, pick;
        sel       = 1;
        rst       = 1'b0;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        req_addr1 = AW'(3);
        req_addr2 = AW'(5);
        bl1       = '0;
        bl2       = '0;

        // Reset held with a request pending: everything stays quiet.
        repeat (3) @(negedge clk);
        chk("rst_en_a", 32'({re1_a, re2_a}), 32'd0);
        chk("rst_en_b", 32'({re1_b, re2_b}), 32'd0);
        chk("rst_vld", 32'({vld_a, vld_b}), 32'd0);
        chk("rst_rdy", 32'({rdy_a, rdy_b}), 32'd0);
        chk("rst_data", 32'({d1_a, d2_a, d1_b, d2_b}), 32'd0);
        chk("rst_err", 32'({err_a, err_b}), 32'd0);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 32'({rdy_a, rdy_b}), 32'd3);

        // Basic reads, one- and three-cycle settle.
        xact(1, 3, 5, 'hA5, 'h3C, 0, 0, 0, 0, 0, 0, 0);
        xact(3, 3, 5, 'hA5, 'h3C, 0, 0, 0, 0, 0, 0, 0);
        // Zero register and out-of-range index.
        xact(1, 0, 17, 'hFF, 'hFF, 0, 0, 0, 0, 0, 0, 0);
        xact(3, 17, 0, 'hFF, 'hFF, 0, 0, 0, 0, 0, 0, 0);
        // Forwarding on the capture edge, same index on both ports.
        xact(3, 7, 7, 'h11, 'h11, 1, 7, 'h42, 0, 0, 0, 0);
        xact(1, 7, 7, 'h11, 'h11, 1, 7, 'h42, 0, 0, 0, 0);
        // A write before the capture edge is not forwarded.
        xact(3, 7, 7, 'h11, 'h11, 0, 7, 'h42, 1, 7, 'h99, 0);
        // A write to register 0 never forwards.
        xact(3, 0, 0, 'h11, 'h11, 1, 0, 'h42, 0, 0, 0, 0);
        // Backpressure with a second request waiting.
        xact(3, 2, 12, 'h5A, 'hC3, 0, 0, 0, 0, 0, 0, 4);

        // Reset during DRIVE clears enables without a clock edge.
        sel = 3;
        wait_idle();
        req_addr1 = AW'(4);
        req_addr2 = AW'(6);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_en1_before", 32'(o_re1), 32'h10);
        #1 rst = 1'b0;
        #1;
        chk("mid_en1_async", 32'(o_re1), 32'd0);
        chk("mid_en2_async", 32'(o_re2), 32'd0);
        chk("mid_vld_async", 32'(o_vld), 32'd0);
        @(negedge clk);
        chk("mid_vld_held", 32'(o_vld), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        xact(3, 4, 6, 'h77, 'h88, 0, 0, 0, 0, 0, 0, 0);

        // Randomized reads.
        for (int i = 0; i < 24; i++) begin
            s  = ($urandom_range(0, 1) == 0) ? 1 : 3;
            a1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
            a2 = ($urandom_range(0, 4) == 0) ? a1 : int'($urandom_range(0, 31));
            cwe  = int'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 3));
            cwa  = (pick == 0) ? a1 : (pick == 1) ? a2 : (pick == 2) ? 0 : int'($urandom_range(0, 31));
            ewe  = int'($urandom_range(0, 1));
            ewa  = ($urandom_range(0, 1) == 0) ? a1 : a2;
            xact(s, a1, a2, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 cwe, cwa, int'($urandom_range(0, 255)),
                 ewe, ewa, int'($urandom_range(0, 255)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
